// File: rtl/system_sysid_checker.sv
// Reads the two sysid words (ID, build timestamp) over Avalon-MM and compares them
// against expected values. Define SYSID_CHECKER_TIMEOUT_EN to add a per-read stall timeout.
module system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1394485293,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        err_id,
  output logic        err_ts,
  output logic        err_timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD_ID = 2'd1;
  localparam logic [1:0] RD_TS = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic       timeout_hit;
  logic       id_mismatch;
  logic       ts_mismatch;

  // Bus outputs decode straight from state, so they cannot move while the slave stalls.
  assign busy        = (state == RD_ID) || (state == RD_TS);
  assign avm_read    = busy;
  assign avm_address = (state == RD_TS);
  assign done        = (state == DONE);

  assign id_mismatch = (avm_readdata != EXPECTED_ID);
  assign ts_mismatch = (avm_readdata != EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic [15:0] stall_cnt;

  // Fires on the edge that completes the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign timeout_hit = busy && avm_waitrequest &&
                       (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (busy && avm_waitrequest) stall_cnt <= stall_cnt + 16'd1;
      else                         stall_cnt <= '0;

      if (state == IDLE && start) err_timeout <= 1'b0;
      else if (timeout_hit)       err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // NOTE: state and captured results use non-blocking assignments so every register
  // samples the pre-edge values; reset is checked first so it beats start and read completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      id_value        <= '0;
      timestamp_value <= '0;
      pass            <= 1'b0;
      err_id          <= 1'b0;
      err_ts          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state           <= RD_ID;
            id_value        <= '0;
            timestamp_value <= '0;
            pass            <= 1'b0;
            err_id          <= 1'b0;
            err_ts          <= 1'b0;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            id_value <= avm_readdata;
            err_id   <= id_mismatch;
            state    <= RD_TS;
          end else if (timeout_hit) begin
            pass  <= 1'b0;
            state <= DONE;
          end
        end
        RD_TS: begin
          if (!avm_waitrequest) begin
            timestamp_value <= avm_readdata;
            err_ts          <= ts_mismatch;
            // A timeout cannot have occurred on this path, so only the word errors matter.
            pass            <= !(err_id || ts_mismatch);
            state           <= DONE;
          end else if (timeout_hit) begin
            pass  <= 1'b0;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_system_sysid_checker.sv
// Self-checking bench for system_sysid_checker: transaction-level reference model compared
// every cycle, plus directed literal checks. Honours SYSID_CHECKER_TIMEOUT_EN.
module tb_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1394485293;
`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        busy, done, pass;
  logic [31:0] id_value, timestamp_value;
  logic        err_id, err_ts, err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  system_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TB_TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_value        (id_value),
    .timestamp_value (timestamp_value),
    .err_id          (err_id),
    .err_ts          (err_ts),
    .err_timeout     (err_timeout)
  );

  always #5 clock = ~clock;

  logic [71:0] dut_vec;
  assign dut_vec = {busy, done, pass, avm_read, avm_address, err_id, err_ts, err_timeout,
                    id_value, timestamp_value};

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int          stall_n   = 0;
  bit          rand_mode = 1'b0;
  bit          stuck     = 1'b0;
  logic [31:0] id_data   = '0;
  logic [31:0] ts_data   = '0;

  initial begin
    int  wcnt;
    bit  acc;
    wcnt = 0;
    forever begin
      @(negedge clock);
      acc = avm_read && !avm_waitrequest;
      @(posedge clock);
      #1;
      if (acc || !avm_read) wcnt = 0;
      if (stuck)          avm_waitrequest = 1'b1;
      else if (rand_mode) avm_waitrequest = ($urandom_range(0, 3) == 0);
      else                avm_waitrequest = avm_read && (wcnt < stall_n);
      if (avm_read && avm_waitrequest) wcnt++;
      avm_readdata = !avm_read ? $urandom : (avm_address ? ts_data : id_data);
    end
  end

  // ---------------- reference model ----------------
  // A check is a list of word reads still owed; it finishes when the list empties or stalls time out.
  int          pend[$];
  bit          m_done, m_pass, m_eid, m_ets, m_eto;
  logic [31:0] m_id, m_ts;
  int          m_stall;
  bit          chk_en = 1'b0;

  task automatic finish_check();
    m_done = 1'b1;
    m_pass = !(m_eid || m_ets || m_eto);
  endtask

  initial begin
    logic [71:0] exp_vec;
    bit          rd;
    pend.delete();
    {m_done, m_pass, m_eid, m_ets, m_eto} = '0;
    m_id = '0; m_ts = '0; m_stall = 0;
    forever begin
      @(negedge clock);
      rd = (pend.size() != 0);
      exp_vec = {rd, m_done, m_pass, rd, rd ? pend[0] == 1 : 1'b0, m_eid, m_ets, m_eto, m_id, m_ts};
      if (chk_en) check("cycle_compare", dut_vec, exp_vec);

      if (reset) begin
        pend.delete();
        {m_done, m_pass, m_eid, m_ets, m_eto} = '0;
        m_id = '0; m_ts = '0; m_stall = 0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (!rd) begin
        if (start) begin
          pend = '{0, 1};
          {m_pass, m_eid, m_ets, m_eto} = '0;
          m_id = '0; m_ts = '0; m_stall = 0;
        end
      end else if (!avm_waitrequest) begin
        if (pend[0] == 0) begin
          m_id  = avm_readdata;
          m_eid = (avm_readdata != EXP_ID);
        end else begin
          m_ts  = avm_readdata;
          m_ets = (avm_readdata != EXP_TS);
        end
        void'(pend.pop_front());
        m_stall = 0;
        if (pend.size() == 0) finish_check();
      end else begin
`ifdef SYSID_CHECKER_TIMEOUT_EN
        m_stall++;
        if (m_stall == TB_TIMEOUT) begin
          m_eto = 1'b1;
          pend.delete();
          finish_check();
        end
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_check(output int lat);
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    lat = 1;
    while (!done && lat < 300) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n;
    repeat (3) @(posedge clock);
    #1; reset = 1'b0;
    chk_en = 1'b1;
    check("reset_state", dut_vec, 72'd0);

    // Zero-wait, matching words
    id_data = EXP_ID; ts_data = EXP_TS; stall_n = 0;
    run_check(lat);
    check("zero_wait_latency", 72'(lat), 72'd3);
    check("zero_wait_flags", {done, pass, err_id, err_ts, err_timeout}, 5'b11000);
    check("zero_wait_values", {id_value, timestamp_value}, {32'd0, 32'd1394485293});

    // ID mismatch still reads the timestamp
    id_data = 32'h0000_0005;
    run_check(lat);
    check("id_mismatch_latency", 72'(lat), 72'd3);
    check("id_mismatch_flags", {pass, err_id, err_ts, err_timeout}, 4'b0100);
    check("id_mismatch_values", {id_value, timestamp_value}, {32'h5, 32'd1394485293});

    // Four stall cycles on each read
    id_data = EXP_ID; stall_n = 4;
    run_check(lat);
    check("stall4_latency", 72'(lat), 72'd11);
    check("stall4_pass", {done, pass}, 2'b11);

    // Timestamp mismatch
    stall_n = 1; ts_data = 32'hDEAD_BEEF;
    run_check(lat);
    check("ts_mismatch_flags", {pass, err_id, err_ts}, 3'b001);
    check("ts_mismatch_value", 72'(timestamp_value), 72'hDEAD_BEEF);

    // Values and pass hold after DONE until the next start
    repeat (3) @(posedge clock);
    #1;
    check("hold_after_done", {busy, done, pass, err_ts, timestamp_value}, {4'b0001, 32'hDEAD_BEEF});

    // Start during RD_ID and coincident with done are ignored
    ts_data = EXP_TS; stall_n = 2;
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1;                 // now in RD_ID, start still high
    @(posedge clock); #1; start = 1'b0;
    lat = 2;
    while (!done && lat < 300) begin
      @(posedge clock); #1;
      lat++;
    end
    check("ignore_start_latency", 72'(lat), 72'd7);
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    check("start_with_done_ignored", {busy, done, avm_read}, 3'b000);

    // Reset in the middle of the timestamp read
    stall_n = 3;
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    n = 0;
    while (!avm_address && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("reached_rd_ts", 72'(avm_address), 72'd1);
    reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    check("reset_mid_read", dut_vec, 72'd0);

`ifdef SYSID_CHECKER_TIMEOUT_EN
    // Slave stuck in waitrequest
    stuck = 1'b1;
    run_check(lat);
    check("timeout_latency", 72'(lat), 72'(TB_TIMEOUT + 1));
    check("timeout_flags", {done, pass, err_id, err_ts, err_timeout}, 5'b10001);
    check("timeout_values", {id_value, timestamp_value}, 64'd0);
    @(posedge clock); #1;
    check("timeout_after", {done, avm_read, busy}, 3'b000);
    stuck = 1'b0;
`endif

    // Randomised traffic against the reference model
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      start   = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 199) == 0);
      id_data = $urandom_range(0, 1) ? EXP_ID : 32'($urandom_range(0, 3));
      ts_data = $urandom_range(0, 1) ? EXP_TS : $urandom;
    end
    @(posedge clock); #1;
    start = 1'b0; reset = 1'b0;
    repeat (4) @(posedge clock);

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
